proc_ctrl_fsm: RTL and testbench
================================

// Module: proc_ctrl_fsm
// PURPOSE
//  Control sequencer for the 16-bit single-bus processor datapath. Latches a
//  9-bit instruction, then steps through T0..T3. Each step drives the bus-mux
//  selects (rout, din_en, gout), the register load enables, and the ALU
//  A/G/addsub controls. Sits beside the 10-input bus mux and the r0..r7/A/G
//  registers. Pulses done for one cycle when an instruction retires.
// PARAMETERS
//  DATA_W  16  width of din (instruction taken from din[IR_W-1:0])
//  IR_W    9   instruction width, format III_XXX_YYY (opcode, Rx, Ry)
// PORTS
//  clk     in   1       rising-edge clock
//  resetn  in   1       asynchronous active-low reset
//  run     in   1       start request; sampled only in T0
//  din     in   DATA_W  external data; instruction in T0, immediate in T1 (mvi)
//  ir      out  IR_W    latched instruction register
//  rout    out  3       bus-mux register select (0..7 -> r0..r7)
//  din_en  out  1       bus-mux selects din (highest priority)
//  gout    out  1       bus-mux selects aluout (below din_en)
//  rin     out  8       one-hot load enables, bit k loads rk from bus
//  ain     out  1       load ALU A register from bus
//  gin     out  1       load ALU G register (A +/- bus)
//  addsub  out  1       0 = add, 1 = subtract; meaningful only while gin=1
//  done    out  1       one-cycle pulse, instruction complete
// BEHAVIOUR
//  - State register: T0 (idle/fetch), T1, T2, T3, 2-bit binary encoding.
//  - All outputs except ir are combinational from state and ir.
//  - Output defaults: rout=0, din_en=gout=ain=gin=addsub=done=0, rin=0.
//  - Reset (resetn=0, asynchronous): state=T0, ir=0. Reset takes effect
//    immediately, including mid-instruction. In T0 all outputs are at their
//    defaults.
//  - T0: when run=1, ir <= din[IR_W-1:0] and next state is T1. Otherwise
//    hold T0. run is ignored in T1..T3 (no queuing).
//  - Opcodes: 000 mv Rx,Ry | 001 mvi Rx,#din | 010 add Rx,Ry |
//    011 sub Rx,Ry | 100..111 reserved (no-op).
//  - T1, mv:     rout=Y, rin[X]=1, done=1; next T0.
//  - T1, mvi:    din_en=1, rin[X]=1, done=1; next T0. The immediate must be
//    valid on din in this cycle.
//  - T1, add/sub: rout=X, ain=1; next T2.
//  - T1, reserved: done=1 only, no register writes; next T0.
//  - T2 (add/sub): rout=Y, gin=1, addsub=ir[6]; next T3.
//  - T3 (add/sub): gout=1, rin[X]=1, done=1; next T0.
//  - Latency from run sampled in T0 to done: 1 cycle for mv/mvi/reserved,
//    3 cycles for add/sub. A new run is accepted in the cycle after done.
//  - Invariants: at most one of din_en and gout is high; rin is 0 or
//    one-hot; done is never high in T0 or T2.
//  - X==Y is legal: mv R3,R3 rewrites R3; add R3,R3 doubles it.
// TESTING
//  1 Reset: resetn=0 for 2 cycles, then 1 -> all outputs 0, ir=0, state T0.
//    Pulse resetn=0 while in T2 -> outputs 0 at once; next run restarts from T0.
//  2 mvi R2,#0x1234: run=1, din=0x0050; next cycle din=0x1234 -> T1 drives
//    din_en=1, rin=0x04, done=1; following cycle is T0.
//  3 mv R5,R3: din=0x002B with run -> T1 drives rout=3, rin=0x20, done=1,
//    din_en=gout=0.
//  4 add R1,R6: din=0x008E -> T1: rout=1, ain=1. T2: rout=6, gin=1, addsub=0.
//    T3: gout=1, rin=0x02, done=1.
//  5 sub R0,R7: din=0x00C7 -> T2: addsub=1. T3: rin=0x01, done=1. Hold run=1
//    throughout -> no restart until T0; next instruction latched in T0.
//  6 Reserved 0x01C0 -> T1: done=1, rin=0, ain=gin=0. Random opcode sweep
//    (500 instructions) -> invariants hold every cycle.

Source files
------------

// File: rtl/proc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : proc_ctrl_fsm
//  Description : T0..T3 control sequencer for the 16-bit single-bus processor.
//                Latches a 9-bit instruction and drives bus-mux selects,
//                register load enables and ALU controls for each step.
//  Revision    : 1.0 - initial release
// ============================================================================
module proc_ctrl_fsm #(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic [IR_W-1:0]   ir,
  output logic [2:0]        rout,
  output logic              din_en,
  output logic              gout,
  output logic [7:0]        rin,
  output logic              ain,
  output logic              gin,
  output logic              addsub,
  output logic              done
);

  // Instruction format III_XXX_YYY, opcode in the top three bits.
  localparam int c_op_lsb = IR_W - 3;
  localparam int c_rx_lsb = IR_W - 6;
  localparam int c_ry_lsb = IR_W - 9;

  localparam logic [2:0] c_op_mv  = 3'b000;
  localparam logic [2:0] c_op_mvi = 3'b001;
  localparam logic [2:0] c_op_add = 3'b010;
  localparam logic [2:0] c_op_sub = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [IR_W-1:0] r_ir;

  logic [2:0] w_opcode;
  logic [2:0] w_rx;
  logic [2:0] w_ry;
  logic [7:0] w_rx_onehot;
  logic       w_is_arith;

  assign w_opcode    = r_ir[c_op_lsb +: 3];
  assign w_rx        = r_ir[c_rx_lsb +: 3];
  assign w_ry        = r_ir[c_ry_lsb +: 3];
  assign w_rx_onehot = 8'b0000_0001 << w_rx;
  assign w_is_arith  = (w_opcode == c_op_add) || (w_opcode == c_op_sub);

  // Only the low IR_W bits of din carry an instruction; the rest are ignored.
  generate
    if (DATA_W > IR_W) begin : g_din_spare
      logic w_unused_din_hi;
      assign w_unused_din_hi = ^din[DATA_W-1:IR_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == T0 && run) begin
        r_ir <= din[IR_W-1:0];
      end
    end
  end

  assign ir = r_ir;

  always_comb begin
    w_next_state = r_state;
    rout         = 3'd0;
    din_en       = 1'b0;
    gout         = 1'b0;
    rin          = 8'd0;
    ain          = 1'b0;
    gin          = 1'b0;
    addsub       = 1'b0;
    done         = 1'b0;

    case (r_state)
      T0: begin
        if (run) begin
          w_next_state = T1;
        end
      end

      T1: begin
        case (w_opcode)
          c_op_mv: begin
            rout         = w_ry;
            rin          = w_rx_onehot;
            done         = 1'b1;
            w_next_state = T0;
          end
          c_op_mvi: begin
            din_en       = 1'b1;
            rin          = w_rx_onehot;
            done         = 1'b1;
            w_next_state = T0;
          end
          c_op_add, c_op_sub: begin
            rout         = w_rx;
            ain          = 1'b1;
            w_next_state = T2;
          end
          default: begin
            // Reserved opcodes retire as a no-op.
            done         = 1'b1;
            w_next_state = T0;
          end
        endcase
      end

      T2: begin
        if (w_is_arith) begin
          rout   = w_ry;
          gin    = 1'b1;
          addsub = w_opcode[0];
        end
        w_next_state = T3;
      end

      T3: begin
        if (w_is_arith) begin
          gout = 1'b1;
          rin  = w_rx_onehot;
          done = 1'b1;
        end
        w_next_state = T0;
      end

      default: begin
        w_next_state = T0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_proc_ctrl_fsm
//  Description : Directed vector table, reset corner cases and a random
//                opcode sweep with invariant checks for proc_ctrl_fsm.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_ctrl_fsm;

  logic        clk;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic [8:0]  ir;
  logic [2:0]  rout;
  logic        din_en;
  logic        gout;
  logic [7:0]  rin;
  logic        ain;
  logic        gin;
  logic        addsub;
  logic        done;

  int checks;
  int failures;

  proc_ctrl_fsm #(.DATA_W(16), .IR_W(9)) dut (
    .clk    (clk),
    .resetn (resetn),
    .run    (run),
    .din    (din),
    .ir     (ir),
    .rout   (rout),
    .din_en (din_en),
    .gout   (gout),
    .rin    (rin),
    .ain    (ain),
    .gin    (gin),
    .addsub (addsub),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ir, rout, din_en, gout, rin, ain, gin, addsub, done}
  logic [25:0] w_act;
  assign w_act = {ir, rout, din_en, gout, rin, ain, gin, addsub, done};

  typedef struct {
    logic        run;
    logic [15:0] din;
    logic [25:0] exp;
    string       name;
  } vec_t;

  localparam int c_nvec = 21;
  vec_t vecs[c_nvec];

  function automatic logic [25:0] pk(logic [8:0] i, logic [2:0] r, logic de,
                                     logic go, logic [7:0] ri, logic a,
                                     logic g, logic s, logic d);
    return {i, r, de, go, ri, a, g, s, d};
  endfunction

  function automatic vec_t mk(string name, logic rn, logic [15:0] dn,
                              logic [25:0] e);
    vec_t v;
    v.name = name;
    v.run  = rn;
    v.din  = dn;
    v.exp  = e;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected value of each row holds for the cycle in which it is checked;
  // run/din of the row are then driven for the next rising edge.
  initial begin
    vecs[0]  = mk("t0_idle",     1'b1, 16'h0050, pk(9'h000, 3'd0, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs[1]  = mk("mvi_t1",      1'b0, 16'h1234, pk(9'h050, 3'd0, 1, 0, 8'h04, 0, 0, 0, 1));
    vecs[2]  = mk("mvi_after",   1'b1, 16'h002B, pk(9'h050, 3'd0, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs[3]  = mk("mv_t1",       1'b0, 16'h0000, pk(9'h02B, 3'd3, 0, 0, 8'h20, 0, 0, 0, 1));
    vecs[4]  = mk("mv_after",    1'b1, 16'h008E, pk(9'h02B, 3'd0, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs[5]  = mk("add_t1",      1'b0, 16'h0000, pk(9'h08E, 3'd1, 0, 0, 8'h00, 1, 0, 0, 0));
    vecs[6]  = mk("add_t2",      1'b0, 16'h0000, pk(9'h08E, 3'd6, 0, 0, 8'h00, 0, 1, 0, 0));
    vecs[7]  = mk("add_t3",      1'b0, 16'h0000, pk(9'h08E, 3'd0, 0, 1, 8'h02, 0, 0, 0, 1));
    vecs[8]  = mk("add_after",   1'b1, 16'h00C7, pk(9'h08E, 3'd0, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs[9]  = mk("sub_t1",      1'b1, 16'h01FF, pk(9'h0C7, 3'd0, 0, 0, 8'h00, 1, 0, 0, 0));
    vecs[10] = mk("sub_t2",      1'b1, 16'h01FF, pk(9'h0C7, 3'd7, 0, 0, 8'h00, 0, 1, 1, 0));
    vecs[11] = mk("sub_t3",      1'b1, 16'h01C0, pk(9'h0C7, 3'd0, 0, 1, 8'h01, 0, 0, 0, 1));
    vecs[12] = mk("sub_after",   1'b1, 16'h01C0, pk(9'h0C7, 3'd0, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs[13] = mk("rsvd_t1",     1'b0, 16'h0000, pk(9'h1C0, 3'd0, 0, 0, 8'h00, 0, 0, 0, 1));
    vecs[14] = mk("rsvd_after",  1'b1, 16'h009B, pk(9'h1C0, 3'd0, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs[15] = mk("addxx_t1",    1'b0, 16'h0000, pk(9'h09B, 3'd3, 0, 0, 8'h00, 1, 0, 0, 0));
    vecs[16] = mk("addxx_t2",    1'b0, 16'h0000, pk(9'h09B, 3'd3, 0, 0, 8'h00, 0, 1, 0, 0));
    vecs[17] = mk("addxx_t3",    1'b0, 16'h0000, pk(9'h09B, 3'd0, 0, 1, 8'h08, 0, 0, 0, 1));
    vecs[18] = mk("addxx_after", 1'b1, 16'hFE2B, pk(9'h09B, 3'd0, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs[19] = mk("mv_hi_din",   1'b0, 16'h0000, pk(9'h02B, 3'd3, 0, 0, 8'h20, 0, 0, 0, 1));
    vecs[20] = mk("mv_hi_after", 1'b0, 16'h0000, pk(9'h02B, 3'd0, 0, 0, 8'h00, 0, 0, 0, 0));
  end

  logic [1:0] m_state;
  logic [8:0] m_ir;
  logic       m_done;
  int         issued;
  int         cyc;

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    run      = 1'b0;
    din      = 16'h0000;

    // Power-on reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", 32'(w_act), 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < c_nvec; i++) begin
      @(negedge clk);
      chk(vecs[i].name, 32'(w_act), 32'(vecs[i].exp));
      run = vecs[i].run;
      din = vecs[i].din;
    end

    // Asynchronous reset while an add sits in T2
    @(negedge clk);
    run = 1'b1;
    din = 16'h008E;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("pre_rst_t2", 32'(w_act), 32'(pk(9'h08E, 3'd6, 0, 0, 8'h00, 0, 1, 0, 0)));
    #2 resetn = 1'b0;
    #1 chk("async_rst", 32'(w_act), 32'h0);
    @(negedge clk);
    chk("rst_low", 32'(w_act), 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_release_t0", 32'(w_act), 32'h0);
    run = 1'b1;
    din = 16'h0050;
    @(negedge clk);
    chk("restart_mvi_t1", 32'(w_act), 32'(pk(9'h050, 3'd0, 1, 0, 8'h04, 0, 0, 0, 1)));
    run = 1'b0;

    // Random opcode sweep against a small state model
    m_state = 2'd0;
    m_ir    = 9'h050;
    issued  = 0;
    cyc     = 0;
    while (!(issued >= 500 && m_state == 2'd0)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 5000) begin
        chk("sweep_budget", 32'(cyc), 32'd5000);
        break;
      end
      m_done = (m_state == 2'd1 && m_ir[8:7] != 2'b01) || (m_state == 2'd3);
      chk("sw_ir", 32'(ir), 32'(m_ir));
      chk("sw_bus_excl", 32'(din_en & gout), 32'd0);
      chk("sw_rin_onehot0", 32'($onehot0(rin)), 32'd1);
      chk("sw_done", 32'(done), 32'(m_done));
      if (m_state == 2'd0) begin
        chk("sw_t0_defaults", 32'(w_act[16:0]), 32'd0);
      end
      din = 16'($urandom);
      if (m_state == 2'd0) begin
        run = (issued < 500) && ($urandom_range(7) != 0);
      end else begin
        run = ($urandom_range(1) != 0);
      end
      case (m_state)
        2'd0: if (run) begin
          m_ir    = din[8:0];
          m_state = 2'd1;
          issued++;
        end
        2'd1: m_state = (m_ir[8:7] == 2'b01) ? 2'd2 : 2'd0;
        2'd2: m_state = 2'd3;
        default: m_state = 2'd0;
      endcase
    end
    run = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
